hex_display_scanner: RTL and testbench

//  Time-multiplexes one hex_decoder across NUM_DIGITS common-anode 7-seg digits (score/level readout).

---
 rtl/seg_pkg.sv | 13 +
 rtl/hex_decoder.sv | 35 +++
 rtl/hex_display_scanner.sv | 142 ++++++++++++++
 tb/tb_hex_display_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path:
// dark pattern, digit width and write-port FSM states.
package seg_pkg;

   localparam logic [6:0] SEG_DARK = 7'h7F;
   localparam int         DIGIT_W  = 4;

   typedef enum logic {
      WR_IDLE    = 1'b0,
      WR_PENDING = 1'b1
   } wr_state_t;

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to active-low 7-seg pattern {g..a}.
// Ports: nibble, en (0 = dark) -> segments_n.
module hex_decoder
   import seg_pkg::*;
(
   input  logic [DIGIT_W-1:0] nibble,
   input  logic               en,
   output logic [6:0]         segments_n
);

   always_comb begin
      segments_n = SEG_DARK;
      if (en) begin
         unique case (nibble)
            4'h0: segments_n = 7'h40;
            4'h1: segments_n = 7'h79;
            4'h2: segments_n = 7'h24;
            4'h3: segments_n = 7'h30;
            4'h4: segments_n = 7'h19;
            4'h5: segments_n = 7'h12;
            4'h6: segments_n = 7'h02;
            4'h7: segments_n = 7'h78;
            4'h8: segments_n = 7'h00;
            4'h9: segments_n = 7'h10;
            4'hA: segments_n = 7'h08;
            4'hB: segments_n = 7'h03;
            4'hC: segments_n = 7'h46;
            4'hD: segments_n = 7'h21;
            4'hE: segments_n = 7'h06;
            4'hF: segments_n = 7'h0E;
         endcase
      end
   end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed 7-seg scanner with double-buffered valid/ready image write.
// Ports: clk, resetn, wr_valid/ready/value/enable, blank_leading_zeros, blink_mask -> digit_sel_n, segments_n.
module hex_display_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 32
)(
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] wr_value,
   input  logic [NUM_DIGITS-1:0]         wr_enable,
   input  logic                          blank_leading_zeros,
   input  logic [NUM_DIGITS-1:0]         blink_mask,
   output logic [NUM_DIGITS-1:0]         digit_sel_n,
   output logic [6:0]                    segments_n
);

   localparam int TICK_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int FC_W   = $clog2(BLINK_FRAMES) + 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(BLINK_FRAMES - 1);

   logic [TICK_W-1:0]             tick;
   logic [IDX_W-1:0]              idx;
   logic [FC_W-1:0]               frame_cnt;
   logic                          blink_phase;
   logic [DIGIT_W*NUM_DIGITS-1:0] act_val, sh_val;
   logic [NUM_DIGITS-1:0]         act_en, sh_en;
   wr_state_t                     wr_state;

   logic                  tick_last, frame_end;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  zrun;
   logic [DIGIT_W-1:0]    cur_nib;
   logic                  cur_en;
   logic [6:0]            seg_nxt;

   assign tick_last = (tick == TICK_LAST);
   assign frame_end = tick_last && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tick        <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (tick_last) begin
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end else begin
            tick <= tick + TICK_W'(1);
         end
         if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end
      end
   end

   // Commit happens only on frame_end so a frame never mixes images;
   // an accept on frame_end waits for the following frame_end.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_state <= WR_IDLE;
         wr_ready <= 1'b1;
         sh_val   <= '0;
         sh_en    <= '0;
         act_val  <= '0;
         act_en   <= '0;
      end else begin
         unique case (wr_state)
            WR_IDLE: begin
               if (wr_valid) begin
                  sh_val   <= wr_value;
                  sh_en    <= wr_enable;
                  wr_state <= WR_PENDING;
                  wr_ready <= 1'b0;
               end
            end
            WR_PENDING: begin
               if (frame_end) begin
                  act_val  <= sh_val;
                  act_en   <= sh_en;
                  wr_state <= WR_IDLE;
                  wr_ready <= 1'b1;
               end
            end
         endcase
      end
   end

   // Blank a digit when it and everything left of it is zero; digit 0 never blanks.
   always_comb begin
      lz_blank = '0;
      zrun     = blank_leading_zeros;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zrun        = zrun && (act_val[i*DIGIT_W +: DIGIT_W] == '0);
         lz_blank[i] = zrun;
      end
   end

   always_comb begin
      cur_nib = '0;
      cur_en  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib = act_val[i*DIGIT_W +: DIGIT_W];
            cur_en  = act_en[i] && !lz_blank[i]
                      && !(blink_mask[i] && blink_phase);
         end
      end
   end

   hex_decoder u_dec (
      .nibble     (cur_nib),
      .en         (cur_en),
      .segments_n (seg_nxt)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         digit_sel_n <= '1;
         segments_n  <= SEG_DARK;
      end else begin
         digit_sel_n <= ~(NUM_DIGITS'(1) << idx);
         segments_n  <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (4 digits, div 4, 2 blink frames).
// Cycle-level reference model derived from elapsed-cycle arithmetic.
module tb_hex_display_scanner;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int BF    = 2;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [15:0] wr_value = '0;
   logic [3:0]  wr_enable = '0;
   logic        blz = 1'b0;
   logic [3:0]  blink_mask = '0;
   logic [3:0]  digit_sel_n;
   logic [6:0]  segments_n;

   hex_display_scanner #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (DIV),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk                 (clk),
      .resetn              (resetn),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_value            (wr_value),
      .wr_enable           (wr_enable),
      .blank_leading_zeros (blz),
      .blink_mask          (blink_mask),
      .digit_sel_n         (digit_sel_n),
      .segments_n          (segments_n)
   );

   always #5 clk = ~clk;

   // active-high {g..a} glyphs
   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int          cyc;
   logic [15:0] m_val, m_sh_val;
   logic [3:0]  m_en, m_sh_en;
   bit          m_pend;
   logic [3:0]  e_sel = 4'hF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_ready = 1'b1;
   int          total = 0;
   int          bad = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int          d;
      bit          ph, fe, lit;
      logic [15:0] sh;
      if (!resetn) begin
         cyc = 0;
         m_val = '0; m_en = '0;
         m_sh_val = '0; m_sh_en = '0;
         m_pend = 0;
         e_sel = 4'hF; e_seg = 7'h7F; e_ready = 1'b1;
      end else begin
         d   = (cyc / DIV) % N;
         ph  = ((cyc / (FRAME * BF)) % 2) == 1;
         fe  = (cyc % FRAME) == FRAME - 1;
         sh  = m_val >> (4 * d);
         lit = m_en[d] && !(blz && d > 0 && sh == 16'h0)
               && !(blink_mask[d] && ph);
         e_sel = ~(4'b0001 << d);
         e_seg = lit ? ~glyph[sh[3:0]] : 7'h7F;
         if (m_pend) begin
            if (fe) begin
               m_val = m_sh_val; m_en = m_sh_en; m_pend = 0;
            end
         end else if (wr_valid) begin
            m_sh_val = wr_value; m_sh_en = wr_enable; m_pend = 1;
         end
         cyc++;
         e_ready = !m_pend;
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, "/sel"}, 32'(digit_sel_n), 32'(e_sel));
      chk({tag, "/seg"}, 32'(segments_n), 32'(e_seg));
      chk({tag, "/rdy"}, 32'(wr_ready), 32'(e_ready));
   endtask

   task automatic wait_ready(string tag);
      int k;
      for (k = 0; k < 4 * FRAME && !e_ready; k++) step(tag);
      chk({tag, "/ready_timeout"}, 32'(k < 4 * FRAME), 32'd1);
   endtask

   task automatic align(string tag, int ph);
      int k;
      for (k = 0; k < 2 * FRAME && (cyc % FRAME) != ph; k++) step(tag);
      chk({tag, "/align_timeout"}, 32'(k < 2 * FRAME), 32'd1);
   endtask

   task automatic do_write(string tag, logic [15:0] v, logic [3:0] e);
      wait_ready(tag);
      wr_valid = 1'b1; wr_value = v; wr_enable = e;
      step(tag);
      wr_valid = 1'b0;
   endtask

   initial begin
      bit acc;
      // 1 reset
      resetn = 1'b0;
      repeat (3) step("reset");
      chk("rst_sel_const", 32'(digit_sel_n), 32'hF);
      chk("rst_seg_const", 32'(segments_n), 32'h7F);
      chk("rst_rdy_const", 32'(wr_ready), 32'd1);
      resetn = 1'b1;
      repeat (2 * FRAME) step("dark");

      // 2 scan and commit
      do_write("scan", 16'h1234, 4'hF);
      chk("scan_busy_const", 32'(wr_ready), 32'd0);
      wait_ready("scan");
      align("scan", 0);
      step("scan");
      chk("scan_d0_sel", 32'(digit_sel_n), 32'hE);
      chk("scan_d0_seg", 32'(segments_n), 32'h19);
      repeat (2 * FRAME) step("scan");

      // 3 leading zeros
      blz = 1'b1;
      do_write("lz", 16'h0050, 4'hF);
      repeat (2 * FRAME + 2) step("lz");
      do_write("lz0", 16'h0000, 4'hF);
      repeat (2 * FRAME + 2) step("lz0");
      blz = 1'b0;

      // 4 write on frame_end, then ignored write while pending
      wait_ready("fe");
      align("fe", FRAME - 1);
      wr_valid = 1'b1; wr_value = 16'hABCD; wr_enable = 4'hF;
      step("fe");
      chk("fe_pending_const", 32'(wr_ready), 32'd0);
      wr_value = 16'hFFFF;
      repeat (5) step("fe_ign");
      wr_valid = 1'b0;
      repeat (3 * FRAME) step("fe");

      // 5 blink
      blink_mask = 4'b0001;
      repeat (4 * FRAME * BF) step("blink");
      blink_mask = 4'b0000;

      // 6 reset while pending
      wait_ready("rstp");
      align("rstp", 1);
      do_write("rstp", 16'h5678, 4'hF);
      step("rstp");
      resetn = 1'b0;
      repeat (2) step("rstp_rst");
      chk("rstp_sel_const", 32'(digit_sel_n), 32'hF);
      chk("rstp_seg_const", 32'(segments_n), 32'h7F);
      chk("rstp_rdy_const", 32'(wr_ready), 32'd1);
      resetn = 1'b1;
      repeat (2 * FRAME) step("rstp_dark");

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         if (!wr_valid && $urandom_range(0, 5) == 0) begin
            wr_valid  = 1'b1;
            wr_value  = 16'($urandom);
            wr_enable = 4'($urandom);
         end
         if ($urandom_range(0, 39) == 0) blz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) blink_mask = 4'($urandom);
         resetn = ($urandom_range(0, 399) != 0);
         acc = wr_valid && e_ready && resetn;
         step("rand");
         if (acc) wr_valid = 1'b0;
      end
      resetn = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
